mac_operand_sequencer: RTL
==========================

# mac_operand_sequencer

Job-level controller that drives the signed MAC accumulator from the operand side. On a start request it clears the MAC, streams N operand pairs from two synchronous-read buffers (activation A, weight B) into the MAC with one pair per cycle, waits for the accumulation to settle, and returns the final dot product to the downstream consumer over a valid/ready handshake. It sits between the operand SRAMs and one MAC instance in the CNN dot-product datapath.

## Interface
- DATA_WIDTH, 8, operand width (matches MAC operands)
- ACC_WIDTH, 32, accumulator/result width (matches MAC output)
- ADDR_WIDTH, 8, operand buffer address width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE
- start_len  in  ADDR_WIDTH+1  number of operand pairs N (0 allowed)
- start_base_a / start_base_b  in  ADDR_WIDTH each  first address in buffer A / B
- rd_en  out  1  buffer read strobe (both buffers)
- rd_addr_a / rd_addr_b  out  ADDR_WIDTH each  read addresses
- rd_data_a / rd_data_b  in  DATA_WIDTH each  read data, valid the cycle after rd_en
- mac_en  out  1  MAC accumulate enable
- mac_clear  out  1  MAC synchronous clear
- mac_a / mac_b  out  DATA_WIDTH signed each  operands, combinational pass-through of rd_data_a / rd_data_b
- mac_acc  in  ACC_WIDTH signed  MAC accumulator value
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_data  out  ACC_WIDTH signed  captured dot product

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, CAPTURE, DONE.
- IDLE: start_ready=1; on start_valid latch len, base_a, base_b, zero index counter i -> CLEAR.
- CLEAR (1 cycle): mac_clear=1, mac_en=0. -> ISSUE if len≠0, else CAPTURE.
- ISSUE: rd_en=1, rd_addr_a=base_a+i, rd_addr_b=base_b+i (modulo 2^ADDR_WIDTH, wraps silently); i increments; after issuing i=len-1 -> DRAIN.
- mac_en is rd_en delayed one cycle (registered), so MAC sees each rd_data pair exactly once, in order.
- DRAIN (1 cycle): rd_en=0, mac_en=1 for final pair. -> CAPTURE.
- CAPTURE (1 cycle): mac_en=0; result_data <= mac_acc. -> DONE.
- DONE: result_valid=1, result_data stable; on result_ready -> IDLE. No new start accepted until back in IDLE.
- Arithmetic is entirely in the MAC; result is the MAC's ACC_WIDTH two's-complement value, wraparound on overflow passed through unchanged.
- rd_en, rd_addr_*, mac_en, mac_clear, result_valid, result_data are registered outputs.

## Timing
- Reset (async assert, sync deassert externally): state IDLE, start_ready=1 after reset, rd_en=0, rd_addr_*=0, mac_en=0, mac_clear=0, result_valid=0, result_data=0, counters 0.
- Start accepted at edge 0: cycle 1 mac_clear=1; cycles 2..N+1 rd_en=1; cycles 3..N+2 mac_en=1; cycle N+3 CAPTURE; result_valid=1 from cycle N+4.
- N=0: cycle 1 CLEAR, cycle 2 CAPTURE, result_valid=1 from cycle 3 with result_data=0.
- Throughput: one pair per cycle, no bubbles within a job; job overhead 4 cycles + result handshake.
- result_valid stays high with stable data while result_ready=0; handshake at edge k -> result_valid=0 and start_ready=1 in cycle k+1.
- start_valid while not IDLE is ignored (not latched).
- rst_n asserted mid-job: immediate return to IDLE, all outputs to reset values; MAC contents undefined but next job's CLEAR restores correctness.

## Test plan
- Basic: A=[1,2,3,4], B=[5,6,7,8], N=4 -> result_data=70, result_valid first seen cycle 8 after start edge.
- Signed: A=[-128,127], B=[-128,-1], N=2 -> result_data=16384-127=16257.
- N=0 with stale MAC value 99 -> mac_clear pulse, result_data=0 at cycle 3.
- Address wrap: ADDR_WIDTH=8, base_a=254, N=4 -> rd_addr_a sequence 254,255,0,1; result matches reference model.
- Backpressure: hold result_ready=0 for 10 cycles -> result_valid and result_data stable, start_ready=0, extra start_valid ignored; release -> IDLE next cycle, back-to-back job gives correct independent result.
- Reset mid-ISSUE at i=2 of N=8 -> rd_en/mac_en drop immediately, start_ready=1 after release; rerun job yields correct sum.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//
// Job-level controller that feeds one signed MAC from two synchronous-read
// operand buffers (activation A, weight B). A job clears the MAC, streams N
// operand pairs into it at one pair per cycle, lets the final product land,
// captures the accumulator and offers it downstream.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start_valid/ready       job request handshake; start_ready is high only in IDLE
//   start_len               number of operand pairs N (0 allowed)
//   start_base_a/_b         first address in buffer A / B
//   rd_en, rd_addr_a/_b     buffer read strobe and addresses (registered)
//   rd_data_a/_b            buffer read data, valid the cycle after rd_en
//   mac_en, mac_clear       MAC accumulate enable / synchronous clear (registered)
//   mac_a, mac_b            MAC operands, straight from rd_data_a / rd_data_b
//   mac_acc                 MAC accumulator value
//   result_valid/ready      result handshake
//   result_data             captured dot product (registered, held while valid)
//   dbg_state               current FSM state encoding (IDLE=0 ... DONE=5)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until that edge;
// ready may be asserted independently of valid.

module mac_operand_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [ADDR_WIDTH:0]          start_len,
  input  logic [ADDR_WIDTH-1:0]        start_base_a,
  input  logic [ADDR_WIDTH-1:0]        start_base_b,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr_a,
  output logic [ADDR_WIDTH-1:0]        rd_addr_b,
  input  logic [DATA_WIDTH-1:0]        rd_data_a,
  input  logic [DATA_WIDTH-1:0]        rd_data_b,
  output logic                         mac_en,
  output logic                         mac_clear,
  output logic signed [DATA_WIDTH-1:0] mac_a,
  output logic signed [DATA_WIDTH-1:0] mac_b,
  input  logic signed [ACC_WIDTH-1:0]  mac_acc,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic signed [ACC_WIDTH-1:0]  result_data,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ISSUE   = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH:0]          len_q, len_d;
  logic [ADDR_WIDTH-1:0]        base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0]        base_b_q, base_b_d;
  // Number of reads already issued in this job.
  logic [ADDR_WIDTH:0]          i_q, i_d;
  logic                         rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]        rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_WIDTH-1:0]        rd_addr_b_q, rd_addr_b_d;
  logic                         mac_en_q, mac_en_d;
  logic                         mac_clear_q, mac_clear_d;
  logic                         result_valid_q, result_valid_d;
  logic signed [ACC_WIDTH-1:0]  result_data_q, result_data_d;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    base_a_d       = base_a_q;
    base_b_d       = base_b_q;
    i_d            = i_q;
    rd_en_d        = 1'b0;
    rd_addr_a_d    = rd_addr_a_q;
    rd_addr_b_d    = rd_addr_b_q;
    // Read data arrives one cycle after rd_en, so the MAC enable simply
    // trails the read strobe by one cycle.
    mac_en_d       = rd_en_q;
    mac_clear_d    = 1'b0;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          len_d       = start_len;
          base_a_d    = start_base_a;
          base_b_d    = start_base_b;
          i_d         = '0;
          mac_clear_d = 1'b1;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (len_q != '0) begin
          // First read is issued from here so reads start the cycle after CLEAR.
          rd_en_d     = 1'b1;
          rd_addr_a_d = base_a_q + i_q[ADDR_WIDTH-1:0];
          rd_addr_b_d = base_b_q + i_q[ADDR_WIDTH-1:0];
          i_d         = i_q + CNT_ONE;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_ISSUE: begin
        if (i_q != len_q) begin
          // Address sum wraps modulo 2^ADDR_WIDTH by truncation.
          rd_en_d     = 1'b1;
          rd_addr_a_d = base_a_q + i_q[ADDR_WIDTH-1:0];
          rd_addr_b_d = base_b_q + i_q[ADDR_WIDTH-1:0];
          i_d         = i_q + CNT_ONE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        // The last accumulate happened on the edge closing DRAIN, so mac_acc
        // is final here.
        result_data_d  = mac_acc;
        result_valid_d = 1'b1;
        state_d        = S_DONE;
      end

      S_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      base_a_q       <= '0;
      base_b_q       <= '0;
      i_q            <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_a_q    <= '0;
      rd_addr_b_q    <= '0;
      mac_en_q       <= 1'b0;
      mac_clear_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      base_a_q       <= base_a_d;
      base_b_q       <= base_b_d;
      i_q            <= i_d;
      rd_en_q        <= rd_en_d;
      rd_addr_a_q    <= rd_addr_a_d;
      rd_addr_b_q    <= rd_addr_b_d;
      mac_en_q       <= mac_en_d;
      mac_clear_q    <= mac_clear_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign rd_en        = rd_en_q;
  assign rd_addr_a    = rd_addr_a_q;
  assign rd_addr_b    = rd_addr_b_q;
  assign mac_en       = mac_en_q;
  assign mac_clear    = mac_clear_q;
  assign mac_a        = rd_data_a;
  assign mac_b        = rd_data_b;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign dbg_state    = state_q;

endmodule
